// File: rtl/kuuga_run_monitor.sv
// Run controller and event monitor: sequences the managed core's reset, counts run
// cycles and per-channel events, and ends the run on limit, stop or lost progress.
module kuuga_run_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int RESET_HOLD  = 16,
    parameter int CYCLE_LIMIT = 4000,
    parameter int STALL_LIMIT = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    progress,
    input  logic [NUM_CH-1:0]       ch_event,
    output logic                    core_reset,
    output logic                    running,
    output logic                    done,
    output logic                    stall,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [NUM_CH*CNT_W-1:0] ch_count
);

    localparam int HOLD_W  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]   CYCLE_LAST = CNT_W'(CYCLE_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DONE,
        STALL
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STALL_W-1:0]  stall_cnt;
    logic                clear_counts;
    logic                limit_hit;
    logic                stall_hit;

    // Next-state decode; inside RUN the exits are ordered start, stop, cycle limit, stall.
    always_comb begin
        next_state   = state;
        clear_counts = 1'b0;
        limit_hit    = (CYCLE_LIMIT != 0) && (cycle_count == CYCLE_LAST);
        stall_hit    = (STALL_LIMIT != 0) && !progress && (stall_cnt == STALL_LAST);
        case (state)
            IDLE, DONE, STALL: begin
                if (start) begin
                    next_state   = HOLD;
                    clear_counts = 1'b1;
                end
            end
            HOLD: begin
                if (start) begin
                    next_state   = HOLD;
                    clear_counts = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    next_state   = HOLD;
                    clear_counts = 1'b1;
                end else if (stop || limit_hit) begin
                    next_state = DONE;
                end else if (stall_hit) begin
                    next_state = STALL;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            core_reset  <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            stall       <= 1'b0;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            cycle_count <= '0;
            ch_count    <= '0;
        end else begin
            state      <= next_state;
            core_reset <= (next_state == RUN) || (next_state == DONE) || (next_state == STALL);
            running    <= (next_state == RUN);
            done       <= (next_state == DONE);
            stall      <= (next_state == STALL);
            if (clear_counts) begin
                hold_cnt    <= '0;
                stall_cnt   <= '0;
                cycle_count <= '0;
                ch_count    <= '0;
            end else begin
                if (state == HOLD) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                // Counting continues on the exiting RUN cycle; all counters saturate.
                if (state == RUN) begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (progress) begin
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_event[i] && (ch_count[i*CNT_W +: CNT_W] != '1)) begin
                            ch_count[i*CNT_W +: CNT_W] <= ch_count[i*CNT_W +: CNT_W] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kuuga_run_monitor.sv
// Directed bench for kuuga_run_monitor: three parameterisations share clock and reset,
// a per-cycle vector table on the small instance plus hand-written long sequences.
module tb_kuuga_run_monitor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters
    logic         a_start, a_stop, a_progress;
    logic [3:0]   a_event;
    logic         a_core_reset, a_running, a_done, a_stall;
    logic [31:0]  a_cycle;
    logic [127:0] a_ch;

    // Instance B: cycle limit and stall limit coincide
    logic         b_start, b_stop, b_progress;
    logic [0:0]   b_event;
    logic         b_core_reset, b_running, b_done, b_stall;
    logic [15:0]  b_cycle;
    logic [15:0]  b_ch;

    // Instance C: narrow counters, short hold, tiny stall limit, unlimited cycles
    logic         c_start, c_stop, c_progress;
    logic [1:0]   c_event;
    logic         c_core_reset, c_running, c_done, c_stall;
    logic [3:0]   c_cycle;
    logic [7:0]   c_ch;

    kuuga_run_monitor u_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .progress(a_progress),
        .ch_event(a_event), .core_reset(a_core_reset), .running(a_running), .done(a_done),
        .stall(a_stall), .cycle_count(a_cycle), .ch_count(a_ch)
    );

    kuuga_run_monitor #(.NUM_CH(1), .CNT_W(16), .RESET_HOLD(4), .CYCLE_LIMIT(100), .STALL_LIMIT(100)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .progress(b_progress),
        .ch_event(b_event), .core_reset(b_core_reset), .running(b_running), .done(b_done),
        .stall(b_stall), .cycle_count(b_cycle), .ch_count(b_ch)
    );

    kuuga_run_monitor #(.NUM_CH(2), .CNT_W(4), .RESET_HOLD(2), .CYCLE_LIMIT(0), .STALL_LIMIT(3)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .stop(c_stop), .progress(c_progress),
        .ch_event(c_event), .core_reset(c_core_reset), .running(c_running), .done(c_done),
        .stall(c_stall), .cycle_count(c_cycle), .ch_count(c_ch)
    );

    // in = {start, stop, progress, ev[1:0]}, flags = {core_reset, running, done, stall}
    typedef struct {
        logic [4:0] in;
        logic [3:0] flags;
        logic [3:0] cycle;
        logic [3:0] ch0;
        logic [3:0] ch1;
    } vec_t;

    vec_t vecs[19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] in);
        {c_start, c_stop, c_progress, c_event} = in;
        step();
    endtask

    // Pulse start on instance A and wait (bounded) for the run to begin.
    task automatic startA();
        int n;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 0;
        while (!a_running && n < 40) begin
            step();
            n++;
        end
        checkOutput("a_enter_run", 32'(a_running), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        {a_start, a_stop, a_progress, a_event} = '0;
        {b_start, b_stop, b_progress, b_event} = '0;
        {c_start, c_stop, c_progress, c_event} = '0;

        vecs[0]  = '{5'b01000, 4'b0000, 4'd0, 4'd0, 4'd0};
        vecs[1]  = '{5'b10000, 4'b0000, 4'd0, 4'd0, 4'd0};
        vecs[2]  = '{5'b01011, 4'b0000, 4'd0, 4'd0, 4'd0};
        vecs[3]  = '{5'b00100, 4'b1100, 4'd0, 4'd0, 4'd0};
        vecs[4]  = '{5'b00101, 4'b1100, 4'd1, 4'd1, 4'd0};
        vecs[5]  = '{5'b00010, 4'b1100, 4'd2, 4'd1, 4'd1};
        vecs[6]  = '{5'b00011, 4'b1100, 4'd3, 4'd2, 4'd2};
        vecs[7]  = '{5'b00100, 4'b1100, 4'd4, 4'd2, 4'd2};
        vecs[8]  = '{5'b00001, 4'b1100, 4'd5, 4'd3, 4'd2};
        vecs[9]  = '{5'b00000, 4'b1100, 4'd6, 4'd3, 4'd2};
        vecs[10] = '{5'b00001, 4'b1001, 4'd7, 4'd4, 4'd2};
        vecs[11] = '{5'b01011, 4'b1001, 4'd7, 4'd4, 4'd2};
        vecs[12] = '{5'b10000, 4'b0000, 4'd0, 4'd0, 4'd0};
        vecs[13] = '{5'b10000, 4'b0000, 4'd0, 4'd0, 4'd0};
        vecs[14] = '{5'b00000, 4'b0000, 4'd0, 4'd0, 4'd0};
        vecs[15] = '{5'b00100, 4'b1100, 4'd0, 4'd0, 4'd0};
        vecs[16] = '{5'b00101, 4'b1100, 4'd1, 4'd1, 4'd0};
        vecs[17] = '{5'b01111, 4'b1010, 4'd2, 4'd2, 4'd1};
        vecs[18] = '{5'b10000, 4'b0000, 4'd0, 4'd0, 4'd0};

        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_a_flags", 32'({a_core_reset, a_running, a_done, a_stall}), 32'd0);
        checkOutput("rst_a_cycle", a_cycle, 32'd0);
        checkOutput("rst_a_ch_zero", 32'(a_ch == '0), 32'd1);
        checkOutput("rst_b_flags", 32'({b_core_reset, b_running, b_done, b_stall}), 32'd0);
        checkOutput("rst_c_flags", 32'({c_core_reset, c_running, c_done, c_stall}), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("c_vec%0d_flags", i), 32'({c_core_reset, c_running, c_done, c_stall}), 32'(vecs[i].flags));
            checkOutput($sformatf("c_vec%0d_cycle", i), 32'(c_cycle), 32'(vecs[i].cycle));
            checkOutput($sformatf("c_vec%0d_ch0", i), 32'(c_ch[3:0]), 32'(vecs[i].ch0));
            checkOutput($sformatf("c_vec%0d_ch1", i), 32'(c_ch[7:4]), 32'(vecs[i].ch1));
        end

        // Saturation: instance C is in HOLD after the last vector
        {c_start, c_stop, c_progress, c_event} = '0;
        n = 0;
        while (!c_running && n < 20) begin
            step();
            n++;
        end
        checkOutput("c_sat_enter_run", 32'(c_running), 32'd1);
        c_progress = 1'b1;
        c_event = 2'b01;
        repeat (20) step();
        checkOutput("c_sat_ch0", 32'(c_ch[3:0]), 32'd15);
        checkOutput("c_sat_ch1", 32'(c_ch[7:4]), 32'd0);
        checkOutput("c_sat_cycle", 32'(c_cycle), 32'd15);
        checkOutput("c_sat_running", 32'(c_running), 32'd1);
        c_event = 2'b00;
        c_stop = 1'b1;
        step();
        c_stop = 1'b0;
        c_progress = 1'b0;
        checkOutput("c_sat_done", 32'(c_done), 32'd1);
        checkOutput("c_sat_ch0_frozen", 32'(c_ch[3:0]), 32'd15);

        // Run to limit on instance A, progress every 4th cycle
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 0;
        while (!a_core_reset && n < 100) begin
            n++;
            step();
        end
        checkOutput("a_hold_cycles", n, 32'd16);
        checkOutput("a_run_at_release", 32'(a_running), 32'd1);
        n = 0;
        while (a_running && n < 5000) begin
            a_progress = (n % 4 == 3);
            step();
            n++;
        end
        a_progress = 1'b0;
        checkOutput("a_run_cycles", n, 32'd4000);
        checkOutput("a_limit_flags", 32'({a_core_reset, a_running, a_done, a_stall}), 32'b1010);
        checkOutput("a_limit_cycle", a_cycle, 32'd4000);

        // Event counts then stop
        startA();
        a_progress = 1'b1;
        a_event = 4'b0101;
        repeat (10) step();
        a_event = 4'b1000;
        repeat (3) step();
        a_event = 4'b0000;
        a_stop = 1'b1;
        step();
        a_stop = 1'b0;
        checkOutput("a_ev_ch0", a_ch[0 +: 32], 32'd10);
        checkOutput("a_ev_ch1", a_ch[32 +: 32], 32'd0);
        checkOutput("a_ev_ch2", a_ch[64 +: 32], 32'd10);
        checkOutput("a_ev_ch3", a_ch[96 +: 32], 32'd3);
        checkOutput("a_ev_flags", 32'({a_core_reset, a_running, a_done, a_stall}), 32'b1010);
        checkOutput("a_ev_cycle", a_cycle, 32'd14);

        // Stall after 5 progressing cycles
        startA();
        a_progress = 1'b1;
        repeat (5) step();
        a_progress = 1'b0;
        n = 0;
        while (a_running && n < 400) begin
            step();
            n++;
        end
        checkOutput("a_stall_cycles", n, 32'd256);
        checkOutput("a_stall_flags", 32'({a_core_reset, a_running, a_done, a_stall}), 32'b1001);
        checkOutput("a_stall_cycle", a_cycle, 32'd261);
        a_stop = 1'b1;
        step();
        a_stop = 1'b0;
        checkOutput("a_stall_stop_ignored", 32'({a_core_reset, a_running, a_done, a_stall}), 32'b1001);

        // Limit and stall on the same cycle: done wins
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        n = 0;
        while (!b_running && n < 20) begin
            step();
            n++;
        end
        checkOutput("b_enter_run", 32'(b_running), 32'd1);
        n = 0;
        while (b_running && n < 300) begin
            step();
            n++;
        end
        checkOutput("b_run_cycles", n, 32'd100);
        checkOutput("b_flags", 32'({b_core_reset, b_running, b_done, b_stall}), 32'b1010);
        checkOutput("b_cycle", 32'(b_cycle), 32'd100);

        // Restart from RUN at cycle 50
        startA();
        a_progress = 1'b1;
        a_event = 4'b1111;
        repeat (50) step();
        checkOutput("a_restart_pre_cycle", a_cycle, 32'd50);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        checkOutput("a_restart_flags", 32'({a_core_reset, a_running, a_done, a_stall}), 32'b0000);
        checkOutput("a_restart_cycle", a_cycle, 32'd0);
        checkOutput("a_restart_ch_zero", 32'(a_ch == '0), 32'd1);
        n = 0;
        while (!a_running && n < 40) begin
            step();
            n++;
        end
        checkOutput("a_restart_hold", n, 32'd16);
        repeat (5) step();
        checkOutput("a_restart_ch3", a_ch[96 +: 32], 32'd5);

        // Asynchronous reset off a clock edge
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("a_async_core_reset", 32'(a_core_reset), 32'd0);
        checkOutput("a_async_running", 32'(a_running), 32'd0);
        checkOutput("a_async_cycle", a_cycle, 32'd0);
        checkOutput("a_async_ch_zero", 32'(a_ch == '0), 32'd1);
        a_event = 4'b0000;
        a_progress = 1'b0;
        #10;
        reset = 1'b1;
        step();
        checkOutput("a_post_reset_idle", 32'({a_core_reset, a_running, a_done, a_stall}), 32'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kuuga_run_monitor.md
Name: kuuga_run_monitor

Overview:
Synthesisable run controller and event monitor that generalises the fixed-length cycle count and reset release used around kuuga_sc. It sequences the design-under-run's reset and counts run cycles up to a programmable limit. It counts NUM_CH independent event channels, such as cache hits, misses and trace writes, and flags a forward-progress stall. It sits beside the cache top, so the same counting and termination behaviour is available both on-board (ILA-visible) and in simulation.

Parameters:
NUM_CH, 4, number of event-count channels (1..16)
CNT_W, 32, width of the cycle counter and of each event counter
RESET_HOLD, 16, cycles that core_reset is held low after leaving reset (minimum 1)
CYCLE_LIMIT, 4000, run cycles before done asserts; 0 means unlimited
STALL_LIMIT, 256, consecutive run cycles without progress before stall asserts; 0 disables the stall check

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins or restarts a run from IDLE, DONE or STALL
stop  in  1  single-cycle pulse; ends a run early (RUN to DONE)
progress  in  1  forward-progress pulse from the core (e.g. instruction retire)
ch_event  in  NUM_CH  per-channel event pulses, one count per high cycle
core_reset  out  1  active-low reset to the managed core
running  out  1  high while in RUN
done  out  1  sticky; run ended by limit or stop
stall  out  1  sticky; run ended by progress timeout
cycle_count  out  CNT_W  RUN cycles elapsed in the current or last run
ch_count  out  NUM_CH*CNT_W  event counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (reset low, asynchronous): state IDLE. core_reset=0, running=0, done=0, stall=0. All counters are 0, including the internal hold and stall counters.
- State encoding: IDLE, HOLD, RUN, DONE, STALL. All outputs are registered.
- IDLE: core_reset=0. On start go to HOLD; clear cycle_count, ch_count, done and stall.
- HOLD: core_reset=0 for exactly RESET_HOLD cycles, counted from the first HOLD cycle.
- HOLD to RUN: core_reset rises on the same edge as the RUN entry, and running=1 from that edge.
- HOLD ignores stop. start re-enters HOLD and restarts the hold count.
- RUN, cycle counting: cycle_count increments every cycle.
- RUN, event counting: each ch_count[i] increments on every cycle that ch_event[i]=1. Events are counted only in RUN.
- RUN, saturation: counters saturate at all-ones and never wrap.
- RUN, stall counter: resets to 0 on any cycle with progress=1. Otherwise it increments.
- RUN exit priority, highest first:
  (1) start: go to HOLD with all counts cleared.
  (2) stop: go to DONE.
  (3) cycle_count == CYCLE_LIMIT-1 on this edge, with CYCLE_LIMIT != 0: go to DONE, leaving cycle_count = CYCLE_LIMIT.
  (4) stall counter reaches STALL_LIMIT-1 with progress=0, with STALL_LIMIT != 0: go to STALL.
- Same-cycle activity on exit: events and the cycle increment on the exiting cycle are still counted.
- Limit and stall in the same cycle: DONE wins, stall stays 0.
- DONE: running=0, done=1, core_reset stays 1 so the core can be inspected, and counters are frozen. start goes to HOLD.
- STALL: the same as DONE, except stall=1 and done=0.
- stop outside RUN is ignored.
- reset low mid-run: immediate return to IDLE, core_reset=0 asynchronously, and all counts are lost.
- Latency: event to count visible is 1 cycle; start to first HOLD cycle is 1 cycle.

Test Plan:
- Directed, run to limit: reset low 10 cycles then high, start pulse, progress every 4 cycles. Required: core_reset low for 16 cycles and then high. running high for exactly 4000 cycles. done=1, stall=0, cycle_count=4000.
- Directed, event counts: in RUN drive ch_event=4'b0101 for 10 cycles and then 4'b1000 for 3 cycles. Required after stop: ch0=10, ch1=0, ch2=10, ch3=3, with done=1.
- Directed, stall: STALL_LIMIT=256, progress held low after the 5th RUN cycle. Required: stall=1, done=0 and running=0 after exactly 256 progress-free cycles. core_reset stays high.
- Directed, simultaneous limit and stall: CYCLE_LIMIT=STALL_LIMIT=100, progress never asserted. Required: done=1, stall=0, cycle_count=100.
- Directed, restart and async reset: start pulsed in RUN at cycle 50. Required: HOLD is re-entered, core_reset drops, and all counters read 0. Then drop reset mid-RUN off a clock edge. Required: core_reset=0 and running=0 immediately, with no clock edge needed.
- Directed, saturation: CNT_W=4, ch_event[0] held high for 20 RUN cycles. Required: ch0=15 with no wrap.
